// File: rtl/sequence_analyzer_pkg.sv
// Shared state type for the 1010 serial pattern detector.
// Each state name records how much of the pattern has been seen so far.
package sequence_analyzer_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,  // idle, no progress
    S1 = 3'd1,  // seen "1"
    S2 = 3'd2,  // seen "10"
    S3 = 3'd3,  // seen "101"
    S4 = 3'd4   // seen "1010", match
  } state_e;

endpackage

// File: rtl/sequence_analyzer.sv
// Moore detector for the serial pattern 1,0,1,0 (oldest first), with overlapping matches.
// out is decoded from the state register only, so serialInput has no combinational path to it.
module sequence_analyzer
  import sequence_analyzer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic serialInput,
  output logic out
);

  state_e r_state;
  state_e w_next_state;

  // Synchronous reset takes priority over every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S0;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = S0;
    case (r_state)
      S0:      w_next_state = serialInput ? S1 : S0;
      S1:      w_next_state = serialInput ? S1 : S2;
      S2:      w_next_state = serialInput ? S3 : S0;
      S3:      w_next_state = serialInput ? S1 : S4;
      // The trailing "10" of a match is the start of the next one.
      S4:      w_next_state = serialInput ? S3 : S0;
      default: w_next_state = S0;
    endcase
  end

  assign out = (r_state == S4);

endmodule

// File: tb/tb_sequence_analyzer.sv
// Self-checking bench for sequence_analyzer: directed vectors with literal expectations,
// plus a sliding-window model checked on every cycle after the first reset.
module tb_sequence_analyzer;

  logic clk;
  logic reset;
  logic serialInput;
  logic out;

  int n_assert = 0;
  int n_fail   = 0;

  sequence_analyzer dut (
    .clk         (clk),
    .reset       (reset),
    .serialInput (serialInput),
    .out         (out)
  );

  // Clock and initial reset level.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: out=%b required=%b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: out must be 1 exactly when the last four bits sampled since reset are 1,0,1,0.
  logic [3:0] m_hist;
  int         m_cnt;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1;
      m_cnt   = 0;
      m_hist  = 4'b0000;
    end else if (m_valid) begin
      m_hist = {m_hist[2:0], serialInput};
      if (m_cnt < 4) m_cnt++;
    end
    #1;
    if (m_valid) check("model", out, (m_cnt >= 4) && (m_hist == 4'b1010));
  end

  // Driver: apply one bit on the falling edge, check a literal after the rising edge.
  task automatic step(input logic rst, input logic b, input logic exp, input string name);
    @(negedge clk);
    reset       = rst;
    serialInput = b;
    @(posedge clk);
    #2;
    check(name, out, exp);
  endtask

  task automatic run_vec(input logic [15:0] bits, input logic [15:0] exps, input int n,
                         input string name);
    for (int i = n - 1; i >= 0; i--) step(1'b0, bits[i], exps[i], name);
  endtask

  initial begin
    reset       = 1'b1;
    serialInput = 1'b0;

    // 1: 0,1,1,0,0,1,0,1,0 -> match only on the 9th bit, then reset clears it.
    step(1'b1, 1'b0, 1'b0, "t1_reset");
    run_vec(16'b0_0110_0101_0, 16'b0_0000_0000_1, 9, "t1_seq");
    step(1'b1, 1'b1, 1'b0, "t1_reset_after_match");

    // 2: 1,0,1,0,1,0 -> overlapping matches on bits 4 and 6.
    run_vec(16'b101010, 16'b000101, 6, "t2_overlap");

    // 3: 1,0,1,1,0,1,0 -> bit 4 falls back to "1", match only on bit 7.
    step(1'b1, 1'b0, 1'b0, "t3_reset");
    run_vec(16'b1011010, 16'b0000001, 7, "t3_seq");

    // 4: reset while in S3, then 0 must not complete a match.
    step(1'b1, 1'b0, 1'b0, "t4_reset");
    run_vec(16'b101, 16'b000, 3, "t4_prefix");
    step(1'b1, 1'b0, 1'b0, "t4_reset_in_s3");
    step(1'b0, 1'b0, 1'b0, "t4_after_reset");

    // 4b: reset while in S4, then "10" alone is not a match.
    run_vec(16'b1010, 16'b0001, 4, "t4b_prefix");
    step(1'b1, 1'b1, 1'b0, "t4b_reset_in_s4");
    run_vec(16'b10, 16'b00, 2, "t4b_after_reset");

    // 5: eight zeros then eight ones.
    step(1'b1, 1'b0, 1'b0, "t5_reset");
    run_vec(16'h00FF, 16'h0000, 16, "t5_flat");

    // 6: reset held three cycles with input 1,0,1; a following 0 must not match.
    step(1'b1, 1'b1, 1'b0, "t6_reset_hold");
    step(1'b1, 1'b0, 1'b0, "t6_reset_hold");
    step(1'b1, 1'b1, 1'b0, "t6_reset_hold");
    step(1'b0, 1'b0, 1'b0, "t6_after_release");

    // Long continuous repetition: out every second cycle.
    run_vec(16'b1010101010101010, 16'b0001010101010101, 16, "t7_repeat");

    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
